// File: rtl/gmsk_burst_sequencer_if.sv
// Handshake/bus bundle between the GMSK burst sequencer, the modulator and the RF chain.
// master = sequencer side, slave = modulator/RF/controller side.
interface gmsk_burst_sequencer_if #(
    parameter int IQ_WIDTH  = 6,
    parameter int LEN_WIDTH = 8
);
    logic                 sample_strobe;
    logic                 symbol_input_strobe;
    logic                 symbol_iq_strobe;
    logic                 current_symbol;
    logic [IQ_WIDTH-1:0]  modulator_inphase;
    logic [IQ_WIDTH-1:0]  modulator_quadrature;
    logic [IQ_WIDTH-1:0]  rfchain_inphase;
    logic [IQ_WIDTH-1:0]  rfchain_quadrature;
    logic                 iq_valid;
    logic                 fire_burst;
    logic [LEN_WIDTH-1:0] payload_len;
    logic                 payload_src_sel;
    logic                 payload_bit;
    logic                 payload_ready;
    logic                 is_armed;
    logic                 burst_done;
    logic [7:0]           lfsr;

    modport master (
        output sample_strobe, current_symbol, rfchain_inphase, rfchain_quadrature,
               iq_valid, payload_ready, is_armed, burst_done, lfsr,
        input  symbol_input_strobe, symbol_iq_strobe, modulator_inphase,
               modulator_quadrature, fire_burst, payload_len, payload_src_sel, payload_bit
    );

    modport slave (
        input  sample_strobe, current_symbol, rfchain_inphase, rfchain_quadrature,
               iq_valid, payload_ready, is_armed, burst_done, lfsr,
        output symbol_input_strobe, symbol_iq_strobe, modulator_inphase,
               modulator_quadrature, fire_burst, payload_len, payload_src_sel, payload_bit
    );
endinterface

// File: rtl/gmsk_burst_sequencer.sv
// GMSK burst framer: primes the modulator, then emits head tail / payload / tail / flush per fire_burst.
// Symbol lookahead updates 1 clk after a consume edge; I/Q path is 2 clks; no backpressure, the modulator paces everything.
module gmsk_burst_sequencer #(
    parameter int         IQ_WIDTH          = 6,
    parameter int         CLOCKS_PER_SAMPLE = 5,
    parameter int         PRIME_SYMBOLS     = 4,
    parameter int         TAIL_SYMBOLS      = 3,
    parameter int         FLUSH_SYMBOLS     = 3,
    parameter int         LEN_WIDTH         = 8,
    parameter int         IDLE_IQ           = 1,
    parameter logic [7:0] LFSR_SEED         = 8'h45,
    parameter logic [7:0] LFSR_TAPS         = 8'h2d
) (
    input logic                    clock,
    input logic                    reset,
    gmsk_burst_sequencer_if.master bus
);

    localparam logic [2:0] ST_PRIME      = 3'd0;
    localparam logic [2:0] ST_PRIME_WAIT = 3'd1;
    localparam logic [2:0] ST_ARMED      = 3'd2;
    localparam logic [2:0] ST_HEAD       = 3'd3;
    localparam logic [2:0] ST_PAYLOAD    = 3'd4;
    localparam logic [2:0] ST_TAIL       = 3'd5;
    localparam logic [2:0] ST_FLUSH      = 3'd6;

    localparam int PT_MAX    = (PRIME_SYMBOLS > TAIL_SYMBOLS) ? PRIME_SYMBOLS : TAIL_SYMBOLS;
    localparam int PHASE_MAX = (PT_MAX > FLUSH_SYMBOLS) ? PT_MAX : FLUSH_SYMBOLS;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int SCW       = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;

    localparam logic [PW-1:0]       PRIME_LAST = PW'(PRIME_SYMBOLS - 1);
    localparam logic [PW-1:0]       TAIL_LAST  = PW'(TAIL_SYMBOLS - 1);
    localparam logic [PW-1:0]       FLUSH_LAST = PW'(FLUSH_SYMBOLS - 1);
    localparam logic [SCW-1:0]      SAMP_LAST  = SCW'(CLOCKS_PER_SAMPLE - 1);
    localparam logic [IQ_WIDTH-1:0] IDLE       = IQ_WIDTH'(IDLE_IQ);

    logic [2:0]           state;
    logic [PW-1:0]        phase_cnt;
    logic [PW-1:0]        phase_inc;
    logic [LEN_WIDTH-1:0] pay_rem;
    logic [LEN_WIDTH-1:0] pay_dec;
    logic                 src_ext;
    logic                 sym_in_q;
    logic                 cur_sym;
    logic [7:0]           lfsr_q;
    logic [7:0]           lfsr_step;
    logic                 done_q;

    logic                 consume;
    logic                 head_exit;
    logic                 pay_last;
    logic                 flush_exit;
    logic                 first_pay_sym;
    logic                 next_pay_sym;

    logic                 gate_open;
    logic                 gate_now;
    logic [IQ_WIDTH-1:0]  stage_i;
    logic [IQ_WIDTH-1:0]  stage_q;
    logic                 stage_vld;
    logic [IQ_WIDTH-1:0]  rf_i;
    logic [IQ_WIDTH-1:0]  rf_q;
    logic                 rf_vld;

    logic [SCW-1:0]       samp_cnt;
    logic                 samp_strobe;

    // One consume event per rising edge, however long the modulator holds the request.
    assign consume    = bus.symbol_input_strobe & ~sym_in_q;
    assign lfsr_step  = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
    assign phase_inc  = (phase_cnt == {PW{1'b1}}) ? phase_cnt : phase_cnt + PW'(1);
    assign pay_dec    = (pay_rem == '0) ? pay_rem : pay_rem - LEN_WIDTH'(1);
    assign head_exit  = (state == ST_HEAD) & consume & (phase_cnt == TAIL_LAST);
    assign pay_last   = (pay_rem <= LEN_WIDTH'(1));
    assign flush_exit = (state == ST_FLUSH) & bus.symbol_iq_strobe & (phase_cnt == FLUSH_LAST);

    assign first_pay_sym = src_ext ? bus.payload_bit : lfsr_q[0];
    assign next_pay_sym  = src_ext ? bus.payload_bit : lfsr_step[0];

    // The sample that arrives with the opening iq strobe is part of the burst; the one with the closing strobe is not.
    assign gate_now = ((state == ST_HEAD) & bus.symbol_iq_strobe) | (gate_open & ~flush_exit);

    assign bus.payload_ready      = src_ext & ((head_exit & (pay_rem != '0)) |
                                               ((state == ST_PAYLOAD) & consume & ~pay_last));
    assign bus.is_armed           = (state == ST_ARMED);
    assign bus.current_symbol     = cur_sym;
    assign bus.lfsr               = lfsr_q;
    assign bus.burst_done         = done_q;
    assign bus.sample_strobe      = samp_strobe;
    assign bus.rfchain_inphase    = rf_i;
    assign bus.rfchain_quadrature = rf_q;
    assign bus.iq_valid           = rf_vld;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_PRIME;
            phase_cnt <= '0;
            pay_rem   <= '0;
            src_ext   <= 1'b0;
            sym_in_q  <= 1'b0;
            cur_sym   <= 1'b1;
            lfsr_q    <= LFSR_SEED;
            done_q    <= 1'b0;
        end else begin
            sym_in_q <= bus.symbol_input_strobe;
            done_q   <= flush_exit;
            case (state)
                ST_PRIME: begin
                    if (consume) begin
                        if (phase_cnt == PRIME_LAST) begin
                            state     <= ST_PRIME_WAIT;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_inc;
                        end
                    end
                end
                ST_PRIME_WAIT: begin
                    if (bus.symbol_iq_strobe) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (bus.fire_burst) begin
                        state     <= ST_HEAD;
                        cur_sym   <= 1'b0;
                        pay_rem   <= bus.payload_len;
                        src_ext   <= bus.payload_src_sel;
                        phase_cnt <= '0;
                    end
                end
                ST_HEAD: begin
                    if (head_exit) begin
                        phase_cnt <= '0;
                        if (pay_rem == '0) begin
                            state   <= ST_TAIL;
                            cur_sym <= 1'b0;
                        end else begin
                            state   <= ST_PAYLOAD;
                            cur_sym <= first_pay_sym;
                        end
                    end else if (consume) begin
                        phase_cnt <= phase_inc;
                    end
                end
                ST_PAYLOAD: begin
                    if (consume) begin
                        pay_rem <= pay_dec;
                        if (!src_ext) begin
                            lfsr_q <= lfsr_step;
                        end
                        if (pay_last) begin
                            state   <= ST_TAIL;
                            cur_sym <= 1'b0;
                        end else begin
                            cur_sym <= next_pay_sym;
                        end
                    end
                end
                ST_TAIL: begin
                    if (consume) begin
                        if (phase_cnt == TAIL_LAST) begin
                            state     <= ST_FLUSH;
                            cur_sym   <= 1'b1;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_inc;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_exit) begin
                        state     <= ST_ARMED;
                        phase_cnt <= '0;
                    end else if (bus.symbol_iq_strobe) begin
                        phase_cnt <= phase_inc;
                    end
                end
                default: begin
                    state   <= ST_PRIME;
                    cur_sym <= 1'b1;
                end
            endcase
        end
    end

    // Two-stage I/Q pipe; the valid travels alongside so it doubles as a clean PA enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            gate_open <= 1'b0;
            stage_i   <= IDLE;
            stage_q   <= IDLE;
            stage_vld <= 1'b0;
            rf_i      <= IDLE;
            rf_q      <= IDLE;
            rf_vld    <= 1'b0;
        end else begin
            gate_open <= gate_now;
            stage_i   <= bus.modulator_inphase;
            stage_q   <= bus.modulator_quadrature;
            stage_vld <= gate_now;
            rf_i      <= stage_vld ? stage_i : IDLE;
            rf_q      <= stage_vld ? stage_q : IDLE;
            rf_vld    <= stage_vld;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            samp_cnt    <= '0;
            samp_strobe <= 1'b0;
        end else begin
            samp_cnt    <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + SCW'(1);
            samp_strobe <= (samp_cnt == SAMP_LAST);
        end
    end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Randomized bench for gmsk_burst_sequencer: a modulator/controller model drives bursts and a
// framing model predicts symbols, LFSR, payload handshakes and the gated I/Q window.
module tb_gmsk_burst_sequencer;
    localparam int         IQW   = 6;
    localparam int         LENW  = 8;
    localparam int         CPS   = 5;
    localparam int         PRIME = 4;
    localparam int         TAIL  = 3;
    localparam int         FLUSH = 3;
    localparam int         IDLE  = 1;
    localparam logic [7:0] SEED  = 8'h45;
    localparam logic [7:0] TAPS  = 8'h2d;

    logic clock = 1'b0;
    logic reset = 1'b1;

    gmsk_burst_sequencer_if #(.IQ_WIDTH(IQW), .LEN_WIDTH(LENW)) bus ();

    gmsk_burst_sequencer #(
        .IQ_WIDTH(IQW), .CLOCKS_PER_SAMPLE(CPS), .PRIME_SYMBOLS(PRIME), .TAIL_SYMBOLS(TAIL),
        .FLUSH_SYMBOLS(FLUSH), .LEN_WIDTH(LENW), .IDLE_IQ(IDLE), .LFSR_SEED(SEED), .LFSR_TAPS(TAPS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : 8'h00);
    endfunction

    // Bench-side view of the burst: expected gate for the sample present this cycle, counters of pulses.
    bit             mon_en    = 1'b0;
    bit             exp_gate  = 1'b0;
    bit             g1 = 1'b0, g2 = 1'b0, r1 = 1'b1, r2 = 1'b1;
    logic [IQW-1:0] mi1 = '0, mi2 = '0, mq1 = '0, mq2 = '0;
    int             ss_k      = 0;
    int             ready_cnt = 0;
    int             done_cnt  = 0;
    int             ready_base = 0;
    bit             ext_bits[$];
    logic [7:0]     model_lfsr = SEED;

    always @(negedge clock) begin
        if (mon_en) begin
            bit exp_v;
            bit exp_ss;
            exp_v = g2 && !r2 && !r1;
            chk("iq_valid", bus.iq_valid, exp_v);
            chk("rf_inphase", bus.rfchain_inphase, exp_v ? mi2 : IQW'(IDLE));
            chk("rf_quadrature", bus.rfchain_quadrature, exp_v ? mq2 : IQW'(IDLE));
            if (r1) ss_k = 0;
            else    ss_k++;
            exp_ss = !r1 && (ss_k % CPS == 0);
            chk("sample_strobe", bus.sample_strobe, exp_ss);
            if (bus.payload_ready) ready_cnt++;
            if (bus.burst_done)    done_cnt++;
        end
        g2 = g1;  g1 = exp_gate;
        r2 = r1;  r1 = reset;
        mi2 = mi1; mi1 = bus.modulator_inphase;
        mq2 = mq1; mq1 = bus.modulator_quadrature;
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            bus.modulator_inphase    = IQW'($urandom);
            bus.modulator_quadrature = IQW'($urandom);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // iq_mode: 0 plain iq strobe, 1 gate-opening strobe, 2 flush-closing strobe, 3 no iq strobe.
    task automatic send_sym(input bit exp_sym, input int iq_mode, input bit extra_fire, input int width);
        int w, g1c, g2c, k;
        w   = (width > 0) ? width : int'($urandom_range(1, 3));
        g1c = int'($urandom_range(1, 3));
        g2c = int'($urandom_range(1, 3));
        k   = ready_cnt - ready_base;
        bus.payload_bit = (k < ext_bits.size()) ? ext_bits[k] : 1'($urandom_range(0, 1));
        chk("symbol", bus.current_symbol, exp_sym);
        bus.symbol_input_strobe = 1'b1;
        repeat (w) tick();
        bus.symbol_input_strobe = 1'b0;
        if (extra_fire) begin
            bus.fire_burst  = 1'b1;
            bus.payload_len = LENW'($urandom);
            tick();
            bus.fire_burst  = 1'b0;
        end
        repeat (g1c) tick();
        if (iq_mode != 3) begin
            if (iq_mode == 2) chk("armed_before_close", bus.is_armed, 1'b0);
            bus.symbol_iq_strobe = 1'b1;
            if (iq_mode == 1) exp_gate = 1'b1;
            if (iq_mode == 2) exp_gate = 1'b0;
            tick();
            bus.symbol_iq_strobe = 1'b0;
            if (iq_mode == 2) begin
                chk("armed_after_close", bus.is_armed, 1'b1);
                chk("burst_done_pulse", bus.burst_done, 1'b1);
            end
        end
        repeat (g2c) tick();
    endtask

    task automatic wait_armed();
        int n = 0;
        while (!bus.is_armed && n < 100) begin
            tick();
            n++;
        end
        chk("wait_armed", bus.is_armed, 1'b1);
    endtask

    task automatic prime(input int width);
        for (int p = 0; p < PRIME; p++)
            send_sym(1'b1, (p == PRIME - 1) ? 3 : 0, 1'b0, width);
        chk("prime_wait_not_armed", bus.is_armed, 1'b0);
        bus.symbol_iq_strobe = 1'b1;
        tick();
        bus.symbol_iq_strobe = 1'b0;
        chk("prime_armed", bus.is_armed, 1'b1);
        chk("prime_idle_sym", bus.current_symbol, 1'b1);
    endtask

    task automatic do_burst(input int len, input bit src, input bit extra_fire,
                            input bit use_pat, input logic [31:0] pat);
        bit exp_q[$];
        int done_base;
        ext_bits.delete();
        ready_base = ready_cnt;
        done_base  = done_cnt;
        for (int i = 0; i < TAIL; i++) exp_q.push_back(1'b0);
        for (int k = 0; k < len; k++) begin
            bit b;
            if (src) begin
                b = use_pat ? pat[len-1-k] : 1'($urandom_range(0, 1));
                ext_bits.push_back(b);
            end else begin
                b = model_lfsr[0];
                model_lfsr = lfsr_next(model_lfsr);
            end
            exp_q.push_back(b);
        end
        for (int i = 0; i < TAIL; i++)      exp_q.push_back(1'b0);
        for (int i = 0; i < FLUSH - 1; i++) exp_q.push_back(1'b1);

        wait_armed();
        chk("armed_idle_sym", bus.current_symbol, 1'b1);
        bus.payload_len     = LENW'(len);
        bus.payload_src_sel = src;
        bus.fire_burst      = 1'b1;
        tick();
        bus.fire_burst      = 1'b0;
        chk("fire_preload_sym", bus.current_symbol, 1'b0);
        chk("fire_leaves_armed", bus.is_armed, 1'b0);
        for (int i = 0; i < exp_q.size(); i++)
            send_sym(exp_q[i], (i == 0) ? 1 : (i == exp_q.size() - 1) ? 2 : 0,
                     extra_fire && (i == 1), 0);
        chk("payload_ready_count", ready_cnt - ready_base, src ? len : 0);
        chk("burst_done_count", done_cnt - done_base, 1);
        chk("lfsr_after_burst", bus.lfsr, model_lfsr);
    endtask

    task automatic reset_mid_payload();
        wait_armed();
        bus.payload_len     = LENW'(10);
        bus.payload_src_sel = 1'b0;
        bus.fire_burst      = 1'b1;
        tick();
        bus.fire_burst      = 1'b0;
        for (int i = 0; i < TAIL; i++) send_sym(1'b0, (i == 0) ? 1 : 0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            send_sym(model_lfsr[0], 0, 1'b0, 0);
            model_lfsr = lfsr_next(model_lfsr);
        end
        chk("gate_open_before_reset", bus.iq_valid, 1'b1);
        reset    = 1'b1;
        exp_gate = 1'b0;
        tick();
        chk("rst_iq_valid", bus.iq_valid, 1'b0);
        chk("rst_rf_inphase", bus.rfchain_inphase, IQW'(IDLE));
        chk("rst_rf_quadrature", bus.rfchain_quadrature, IQW'(IDLE));
        chk("rst_lfsr", bus.lfsr, SEED);
        chk("rst_not_armed", bus.is_armed, 1'b0);
        chk("rst_sym", bus.current_symbol, 1'b1);
        tick();
        reset      = 1'b0;
        model_lfsr = SEED;
        bus.fire_burst = 1'b1;
        tick();
        bus.fire_burst = 1'b0;
        chk("fire_in_prime_ignored", bus.current_symbol, 1'b1);
        chk("no_arm_before_prime", bus.is_armed, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.symbol_input_strobe  = 1'b0;
        bus.symbol_iq_strobe     = 1'b0;
        bus.modulator_inphase    = '0;
        bus.modulator_quadrature = '0;
        bus.fire_burst           = 1'b0;
        bus.payload_len          = '0;
        bus.payload_src_sel      = 1'b0;
        bus.payload_bit          = 1'b0;
        tick();
        mon_en = 1'b1;
        repeat (2) tick();
        chk("reset_sample_strobe", bus.sample_strobe, 1'b0);
        chk("reset_current_symbol", bus.current_symbol, 1'b1);
        chk("reset_rf_inphase", bus.rfchain_inphase, IQW'(IDLE));
        chk("reset_rf_quadrature", bus.rfchain_quadrature, IQW'(IDLE));
        chk("reset_iq_valid", bus.iq_valid, 1'b0);
        chk("reset_is_armed", bus.is_armed, 1'b0);
        chk("reset_payload_ready", bus.payload_ready, 1'b0);
        chk("reset_burst_done", bus.burst_done, 1'b0);
        chk("reset_lfsr", bus.lfsr, SEED);
        reset = 1'b0;

        bus.fire_burst = 1'b1;
        tick();
        bus.fire_burst = 1'b0;
        chk("early_fire_ignored", bus.current_symbol, 1'b1);
        prime(3);

        do_burst(8, 1'b0, 1'b1, 1'b0, 32'd0);
        do_burst(4, 1'b1, 1'b0, 1'b1, 32'b1011);
        do_burst(0, 1'b0, 1'b1, 1'b0, 32'd0);
        do_burst(0, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (5)
            do_burst(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0, 32'd0);
        do_burst(255, 1'b0, 1'b0, 1'b0, 32'd0);
        do_burst(255, 1'b1, 1'b0, 1'b0, 32'd0);

        reset_mid_payload();
        prime(1);
        do_burst(5, 1'b0, 1'b0, 1'b0, 32'd0);

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
